// File: rtl/enigma_rotor_stack_pkg.sv
// Shared definitions for the Enigma rotor stack: letter width, rotor and
// reflector wiring tables, turnover letters, FSM state type and the mod-26
// helpers used by both the rotor map and the top-level stepping logic.
package enigma_rotor_stack_pkg;

  localparam int LETTER_W = 5;
  localparam int ALPHABET = 26;

  typedef logic [LETTER_W-1:0] letter_t;
  typedef logic [0:ALPHABET-1][LETTER_W-1:0] table_t;

  typedef enum logic [1:0] {
    WIRE_I   = 2'b00,
    WIRE_II  = 2'b01,
    WIRE_III = 2'b10,
    WIRE_ID  = 2'b11
  } wiring_e;

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_FWD, S_REFL, S_BWD, S_DONE
  } state_e;

  // Rotor I: EKMFLGDQVZNTOWYHXUSPAIBRCJ
  localparam table_t ROTOR_I_FWD = '{
    5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
    5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
  // Rotor II: AJDKSIRUXBLHWTMCQGZNPYFVOE
  localparam table_t ROTOR_II_FWD = '{
    5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
    5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
  // Rotor III: BDFHJLCPRTXVZNYEIWGAKMUSQO
  localparam table_t ROTOR_III_FWD = '{
    5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
    5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
  // UKW-B: YRUHQSLDPXNGOKMIEBFZCWVJAT
  localparam table_t UKW_B = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};
  // UKW-C: FVPJIAOYEDRZXWGCTKUQSBNMHL
  localparam table_t UKW_C = '{
    5'd5, 5'd21, 5'd15, 5'd9, 5'd8, 5'd0, 5'd14, 5'd24, 5'd4, 5'd3, 5'd17, 5'd25, 5'd23,
    5'd22, 5'd6, 5'd2, 5'd19, 5'd10, 5'd20, 5'd16, 5'd18, 5'd1, 5'd13, 5'd12, 5'd7, 5'd11};

  // Turnover letters: I=Q, II=E, III=V
  localparam letter_t TURN_I   = 5'd16;
  localparam letter_t TURN_II  = 5'd4;
  localparam letter_t TURN_III = 5'd21;

  // Builds the inverse permutation at elaboration time so the reverse path
  // tables can never drift out of sync with the forward ones.
  function automatic table_t invert(table_t t);
    table_t r;
    r = '0;
    for (int k = 0; k < ALPHABET; k++) r[t[k]] = letter_t'(k);
    return r;
  endfunction

  localparam table_t ROTOR_I_INV   = invert(ROTOR_I_FWD);
  localparam table_t ROTOR_II_INV  = invert(ROTOR_II_FWD);
  localparam table_t ROTOR_III_INV = invert(ROTOR_III_FWD);

  // Operands are always 0..25, so one conditional correction suffices.
  function automatic letter_t add26(letter_t a, letter_t b);
    logic [LETTER_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (LETTER_W+1)'(ALPHABET)) s = s - (LETTER_W+1)'(ALPHABET);
    return s[LETTER_W-1:0];
  endfunction

  function automatic letter_t sub26(letter_t a, letter_t b);
    logic [LETTER_W:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + (LETTER_W+1)'(ALPHABET) - {1'b0, b};
    return s[LETTER_W-1:0];
  endfunction

  function automatic logic is_notch(wiring_e w, letter_t p);
    case (w)
      WIRE_I:   return p == TURN_I;
      WIRE_II:  return p == TURN_II;
      WIRE_III: return p == TURN_III;
      default:  return 1'b0;
    endcase
  endfunction

  // Reset wiring of rotor index n is n mod 3 (n <= 7, so two subtractions at most).
  function automatic wiring_e default_wiring(int unsigned n);
    int unsigned r;
    r = n;
    for (int k = 0; k < 3; k++) if (r >= 3) r = r - 3;
    return wiring_e'(r[1:0]);
  endfunction

endpackage

// File: rtl/enigma_rotor_stack_if.sv
// Letter handshake between the keyboard decoder (master) and the rotor core
// (slave).
//  in_valid/in_ready/in_letter : plaintext letter handshake
//  out_valid/out_letter/out_err: one-cycle result pulse, no backpressure
interface enigma_rotor_stack_if;
  import enigma_rotor_stack_pkg::*;

  logic    in_valid;
  logic    in_ready;
  letter_t in_letter;
  logic    out_valid;
  letter_t out_letter;
  logic    out_err;

  modport master (
    output in_valid, in_letter,
    input  in_ready, out_valid, out_letter, out_err
  );

  modport slave (
    input  in_valid, in_letter,
    output in_ready, out_valid, out_letter, out_err
  );
endinterface

// File: rtl/enigma_rotor_stack_rotor_map.sv
// Combinational single-rotor substitution, shared by every rotor in both
// directions.
//  c_in    : letter entering the rotor
//  pos     : rotor position, ring : ring setting
//  wiring  : rotor type (identity passes the contact through unchanged)
//  dir_bwd : 0 = forward (right to left), 1 = return path (inverse wiring)
//  c_out   : letter leaving the rotor
module enigma_rotor_map
  import enigma_rotor_stack_pkg::*;
(
  input  letter_t c_in,
  input  letter_t pos,
  input  letter_t ring,
  input  wiring_e wiring,
  input  logic    dir_bwd,
  output letter_t c_out
);

  letter_t off;
  letter_t idx;
  letter_t wired;
  table_t  tbl;

  always_comb begin
    off = sub26(pos, ring);
    idx = add26(c_in, off);
    case (wiring)
      WIRE_I:   tbl = dir_bwd ? ROTOR_I_INV   : ROTOR_I_FWD;
      WIRE_II:  tbl = dir_bwd ? ROTOR_II_INV  : ROTOR_II_FWD;
      WIRE_III: tbl = dir_bwd ? ROTOR_III_INV : ROTOR_III_FWD;
      default:  tbl = '0;
    endcase
    wired = (wiring == WIRE_ID) ? idx : tbl[idx];
    c_out = sub26(wired, off);
  end

endmodule

// File: rtl/enigma_rotor_stack.sv
// N-rotor Enigma core. Each accepted letter steps the rotors, then walks one
// rotor per clock through the forward path, the reflector and the return path.
//  clk, reset         : clock, synchronous active-high reset
//  cfg_load           : load cfg_wiring/cfg_ring/cfg_pos (honoured in IDLE only)
//  cfg_wiring/ring/pos: per-rotor configuration, rotor i at slice i
//  bus                : letter handshake (slave side)
//  pos_out            : current rotor positions, rotor i at slice i
//  busy               : a letter is in flight
module enigma_rotor_stack
  import enigma_rotor_stack_pkg::*;
#(
  parameter int NUM_ROTORS = 3,
  parameter int REFLECTOR  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_load,
  input  logic [2*NUM_ROTORS-1:0]       cfg_wiring,
  input  logic [5*NUM_ROTORS-1:0]       cfg_ring,
  input  logic [5*NUM_ROTORS-1:0]       cfg_pos,
  enigma_rotor_stack_if.slave           bus,
  output logic [5*NUM_ROTORS-1:0]       pos_out,
  output logic                          busy
);

  localparam int IDX_W = $clog2((NUM_ROTORS > 1) ? NUM_ROTORS : 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROTORS - 1);
  localparam table_t UKW = (REFLECTOR == 0) ? UKW_B : UKW_C;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  letter_t          letter_q, letter_d;
  letter_t          out_letter_q, out_letter_d;
  logic             out_err_q, out_err_d;
  letter_t          pos_q [NUM_ROTORS];
  letter_t          pos_d [NUM_ROTORS];
  letter_t          ring_q [NUM_ROTORS];
  letter_t          ring_d [NUM_ROTORS];
  wiring_e          wiring_q [NUM_ROTORS];
  wiring_e          wiring_d [NUM_ROTORS];

  logic [NUM_ROTORS-1:0] notch;
  logic [NUM_ROTORS:0]   carry;
  letter_t               map_out;

  enigma_rotor_map u_map (
    .c_in    (letter_q),
    .pos     (pos_q[idx_q]),
    .ring    (ring_q[idx_q]),
    .wiring  (wiring_q[idx_q]),
    .dir_bwd (state_q == S_BWD),
    .c_out   (map_out)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    letter_d     = letter_q;
    out_letter_d = out_letter_q;
    out_err_d    = out_err_q;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      pos_d[i]    = pos_q[i];
      ring_d[i]   = ring_q[i];
      wiring_d[i] = wiring_q[i];
      notch[i]    = is_notch(wiring_q[i], pos_q[i]);
    end
    // carry[i] = "rotor to the right is at its notch"; rotor 0 always steps.
    carry = {notch, 1'b1};

    case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          for (int i = 0; i < NUM_ROTORS; i++) begin
            wiring_d[i] = wiring_e'(cfg_wiring[2*i +: 2]);
            ring_d[i]   = cfg_ring[5*i +: 5];
            pos_d[i]    = cfg_pos[5*i +: 5];
          end
        end else if (bus.in_valid) begin
          if (bus.in_letter > letter_t'(ALPHABET - 1)) begin
            out_letter_d = bus.in_letter;
            out_err_d    = 1'b1;
            state_d      = S_DONE;
          end else begin
            letter_d = bus.in_letter;
            state_d  = S_STEP;
          end
        end
      end
      S_STEP: begin
        // Second term is the double-step: a middle rotor at its own notch advances again.
        for (int i = 0; i < NUM_ROTORS; i++) begin
          if (carry[i] || ((i < NUM_ROTORS - 1) && notch[i]))
            pos_d[i] = add26(pos_q[i], letter_t'(1));
        end
        idx_d   = '0;
        state_d = S_FWD;
      end
      S_FWD: begin
        letter_d = map_out;
        if (idx_q == LAST_IDX) state_d = S_REFL;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_REFL: begin
        letter_d = UKW[letter_q];
        idx_d    = LAST_IDX;
        state_d  = S_BWD;
      end
      S_BWD: begin
        letter_d = map_out;
        if (idx_q == '0) begin
          out_letter_d = map_out;
          out_err_d    = 1'b0;
          state_d      = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      out_letter_q <= '0;
      out_err_q    <= 1'b0;
      for (int i = 0; i < NUM_ROTORS; i++) begin
        pos_q[i]    <= '0;
        ring_q[i]   <= '0;
        wiring_q[i] <= default_wiring(NUM_ROTORS - 1 - i);
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      out_letter_q <= out_letter_d;
      out_err_q    <= out_err_d;
      for (int i = 0; i < NUM_ROTORS; i++) begin
        pos_q[i]    <= pos_d[i];
        ring_q[i]   <= ring_d[i];
        wiring_q[i] <= wiring_d[i];
      end
    end
  end

  // Working letter carries no reset: it is always written before being used.
  always_ff @(posedge clk) begin
    letter_q <= letter_d;
  end

  always_comb begin
    for (int i = 0; i < NUM_ROTORS; i++) pos_out[5*i +: 5] = pos_q[i];
  end

  assign bus.in_ready   = (state_q == S_IDLE) && !cfg_load;
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_letter = out_letter_q;
  assign bus.out_err    = out_err_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_enigma_rotor_stack.sv
// Directed self-checking bench for enigma_rotor_stack (N=3, UKW-B).
module tb_enigma_rotor_stack;
  import enigma_rotor_stack_pkg::*;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cfg_load = 1'b0;
  logic [2*N-1:0] cfg_wiring = '0;
  logic [5*N-1:0] cfg_ring = '0;
  logic [5*N-1:0] cfg_pos = '0;
  logic [5*N-1:0] pos_out;
  logic           busy;

  int checks = 0;
  int errors = 0;

  enigma_rotor_stack_if bus ();

  enigma_rotor_stack #(.NUM_ROTORS(N), .REFLECTOR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_wiring (cfg_wiring),
    .cfg_ring   (cfg_ring),
    .cfg_pos    (cfg_pos),
    .bus        (bus),
    .pos_out    (pos_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load_cfg(input logic [2*N-1:0] w, input logic [5*N-1:0] r,
                          input logic [5*N-1:0] p);
    @(negedge clk);
    cfg_wiring = w; cfg_ring = r; cfg_pos = p; cfg_load = 1'b1;
    @(posedge clk);
    #1 cfg_load = 1'b0;
  endtask

  // Sends one letter; lat = clock edges from accept to the out_valid cycle, -1 on timeout.
  task automatic send_letter(input logic [4:0] l, output logic [4:0] res,
                             output logic err, output int lat);
    int w;
    lat = -1; res = '0; err = 1'b0;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid = 1'b1; bus.in_letter = l;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = c; res = bus.out_letter; err = bus.out_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               bus.in_ready, bus.out_valid, busy);
    end
    checks++;
    if (bus.out_letter !== 5'd0 || bus.out_err !== 1'b0 || pos_out !== '0) begin
      errors++;
      $display("FAIL reset_data: out_letter=%0d out_err=%b pos_out=%h, want 0 0 0",
               bus.out_letter, bus.out_err, pos_out);
    end
  endtask

  task automatic test_default_aaaaa();
    logic [4:0] exp [5] = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};  // B D Z G O
    logic [4:0] res; logic err; int lat;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_letter(5'd0, res, err, lat);
      checks++;
      if (res !== exp[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL aaaaa_%0d: got %0d err=%b, want %0d err=0", i, res, err, exp[i]);
      end
      if (i == 0) begin
        checks++;
        if (lat != 2*N+3) begin
          errors++;
          $display("FAIL latency: got %0d, want %0d", lat, 2*N+3);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_letter !== 5'd14) begin
      errors++;
      $display("FAIL pulse_hold: out_valid=%b out_letter=%0d, want 0 14",
               bus.out_valid, bus.out_letter);
    end
    checks++;
    if (pos_out !== {5'd0, 5'd0, 5'd5}) begin
      errors++;
      $display("FAIL aaaaa_pos: got %h, want %h", pos_out, {5'd0, 5'd0, 5'd5});
    end
  endtask

  task automatic test_double_step();
    logic [5*N-1:0] exp [3];
    logic [4:0] res; logic err; int lat;
    exp[0] = {5'd0, 5'd3, 5'd21};
    exp[1] = {5'd0, 5'd4, 5'd22};
    exp[2] = {5'd1, 5'd5, 5'd23};
    do_reset();
    load_cfg({2'b00, 2'b01, 2'b10}, '0, {5'd0, 5'd3, 5'd20});
    checks++;
    if (pos_out !== {5'd0, 5'd3, 5'd20}) begin
      errors++;
      $display("FAIL cfg_load_pos: got %h, want %h", pos_out, {5'd0, 5'd3, 5'd20});
    end
    for (int i = 0; i < 3; i++) begin
      send_letter(5'd0, res, err, lat);
      checks++;
      if (pos_out !== exp[i] || lat < 0) begin
        errors++;
        $display("FAIL dstep_%0d: pos_out=%h lat=%0d, want %h", i, pos_out, lat, exp[i]);
      end
    end
  endtask

  task automatic test_reciprocity();
    logic [4:0] pt [5] = '{5'd7, 5'd4, 5'd11, 5'd11, 5'd14};  // HELLO
    logic [4:0] ct [5];
    logic [4:0] res; logic err; int lat;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_letter(pt[i], res, err, lat);
      ct[i] = res;
      checks++;
      if (res === pt[i] || lat < 0) begin
        errors++;
        $display("FAIL enc_self_%0d: got %0d from %0d lat=%0d, want a different letter",
                 i, res, pt[i], lat);
      end
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_letter(ct[i], res, err, lat);
      checks++;
      if (res !== pt[i]) begin
        errors++;
        $display("FAIL recip_%0d: got %0d, want %0d", i, res, pt[i]);
      end
    end
  endtask

  task automatic test_invalid_letter();
    logic [4:0] res; logic err; int lat;
    do_reset();
    send_letter(5'd27, res, err, lat);
    checks++;
    if (lat != 1 || err !== 1'b1 || res !== 5'd27) begin
      errors++;
      $display("FAIL invalid: lat=%0d err=%b letter=%0d, want 1 1 27", lat, err, res);
    end
    checks++;
    if (pos_out !== '0) begin
      errors++;
      $display("FAIL invalid_pos: got %h, want 0", pos_out);
    end
  endtask

  task automatic test_cfg_load_rules();
    int lat; logic [4:0] res; logic seen;
    do_reset();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_letter = 5'd0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    cfg_wiring = '1; cfg_ring = {5'd3, 5'd3, 5'd3}; cfg_pos = {5'd9, 5'd9, 5'd9};
    cfg_load = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 cfg_load = 1'b0;
    lat = -1; res = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin lat = c; res = bus.out_letter; break; end
    end
    checks++;
    if (lat < 0 || res !== 5'd1) begin
      errors++;
      $display("FAIL load_busy_letter: got %0d (timeout=%0d), want 1", res, lat < 0);
    end
    checks++;
    if (pos_out !== {5'd0, 5'd0, 5'd1}) begin
      errors++;
      $display("FAIL load_busy_pos: got %h, want %h", pos_out, {5'd0, 5'd0, 5'd1});
    end
    @(negedge clk);
    cfg_wiring = {2'b00, 2'b01, 2'b10}; cfg_ring = '0; cfg_pos = {5'd2, 5'd4, 5'd6};
    cfg_load = 1'b1; bus.in_valid = 1'b1; bus.in_letter = 5'd3;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready: in_ready=%b, want 0", bus.in_ready);
    end
    @(posedge clk);
    #1 cfg_load = 1'b0; bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy || bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || pos_out !== {5'd2, 5'd4, 5'd6}) begin
      errors++;
      $display("FAIL load_wins: activity=%b pos_out=%h, want 0 %h",
               seen, pos_out, {5'd2, 5'd4, 5'd6});
    end
  endtask

  task automatic test_reset_midflight();
    logic seen; logic [4:0] res; logic err; int lat;
    do_reset();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_letter = 5'd0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || pos_out !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b pos_out=%h in_ready=%b, want 0 0 1",
               bus.out_valid, pos_out, bus.in_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_pulse: out_valid seen=%b, want 0", seen);
    end
    load_cfg('1, '0, '0);
    send_letter(5'd0, res, err, lat);
    checks++;
    if (res !== 5'd24 || lat != 2*N+3) begin
      errors++;
      $display("FAIL identity: got %0d lat=%0d, want 24 lat=%0d", res, lat, 2*N+3);
    end
    checks++;
    if (pos_out !== {5'd0, 5'd0, 5'd1}) begin
      errors++;
      $display("FAIL identity_pos: got %h, want %h", pos_out, {5'd0, 5'd0, 5'd1});
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_letter = '0;
    test_reset();
    test_default_aaaaa();
    test_double_step();
    test_reciprocity();
    test_invalid_letter();
    test_cfg_load_rules();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
